// File: rtl/seg7_disp_arbiter.sv
// seg7_disp_arbiter: fixed-priority owner selection for the shared 7-segment
// driver. A grant stays on screen for at least HOLD_CYC+1 cycles, and every
// owner change goes through one blank cycle that restarts the driver's scan.
//
// Handshake: i_req[n] is a level request, not a valid/ready pair. A requester
// owns the display when o_grant[n] is high. While it owns the display it may
// change its payload live. Once its request drops, the display keeps the last
// payload until the minimum hold time has elapsed.
module seg7_disp_arbiter #(
    parameter int unsigned HOLD_CYC = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] i_req,
    input  logic [2:0] i_mode,
    input  logic [2:0] i_op0,
    input  logic [2:0] i_op1,
    input  logic [2:0] i_op2,
    input  logic [3:0] i_dig0,
    input  logic [3:0] i_dig1,
    input  logic [3:0] i_dig2,
    output logic       o_en,
    output logic       o_disp_mode,
    output logic [2:0] o_op_code,
    output logic [3:0] o_digit_val,
    output logic [2:0] o_grant,
    output logic       o_busy
);
    localparam int CW = $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_LINGER, S_BLANK} state_t;

    state_t        state_q, state_d;
    logic [1:0]    owner_q, owner_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          en_q, en_d;
    logic          mode_q, mode_d;
    logic [2:0]    op_q, op_d;
    logic [3:0]    dig_q, dig_d;
    logic [2:0]    grant_q, grant_d;
    logic          busy_q, busy_d;

    logic [1:0]    win_idx;
    logic [1:0]    sel_idx;
    logic          sel_mode;
    logic [2:0]    sel_op;
    logic [3:0]    sel_dig;
    logic          held;
    logic          own_req;
    logic          higher_req;
    logic [CW-1:0] hold_cnt_inc;

    // Highest-priority requester (lowest set bit) plus owner-relative request views.
    always_comb begin
        win_idx = 2'd0;
        if (i_req[0])      win_idx = 2'd0;
        else if (i_req[1]) win_idx = 2'd1;
        else if (i_req[2]) win_idx = 2'd2;

        own_req    = 1'b0;
        higher_req = 1'b0;
        case (owner_q)
            2'd0:    begin own_req = i_req[0]; higher_req = 1'b0;      end
            2'd1:    begin own_req = i_req[1]; higher_req = i_req[0];  end
            2'd2:    begin own_req = i_req[2]; higher_req = |i_req[1:0]; end
            default: begin own_req = 1'b0;     higher_req = 1'b0;      end
        endcase

        held         = (hold_cnt_q == CW'(HOLD_CYC));
        hold_cnt_inc = held ? hold_cnt_q : hold_cnt_q + CW'(1);
        // A new grant loads the winner's payload; an existing grant reloads the owner's.
        sel_idx      = (state_q == S_IDLE || state_q == S_BLANK) ? win_idx : owner_q;
    end

    // Payload mux for the requester currently being loaded.
    always_comb begin
        sel_mode = 1'b0;
        sel_op   = 3'd0;
        sel_dig  = 4'd0;
        case (sel_idx)
            2'd0:    begin sel_mode = i_mode[0]; sel_op = i_op0; sel_dig = i_dig0; end
            2'd1:    begin sel_mode = i_mode[1]; sel_op = i_op1; sel_dig = i_dig1; end
            2'd2:    begin sel_mode = i_mode[2]; sel_op = i_op2; sel_dig = i_dig2; end
            default: begin sel_mode = 1'b0;      sel_op = 3'd0;  sel_dig = 4'd0;   end
        endcase
    end

    // Next-state and next-output logic; outputs are computed one state ahead so they leave flops.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        en_d       = en_q;
        mode_d     = mode_q;
        op_d       = op_q;
        dig_d      = dig_q;
        grant_d    = grant_q;

        case (state_q)
            S_IDLE, S_BLANK: begin
                if (i_req != 3'b000) begin
                    state_d    = S_SHOW;
                    owner_d    = win_idx;
                    hold_cnt_d = '0;
                    en_d       = 1'b1;
                    grant_d    = 3'b001 << win_idx;
                    mode_d     = sel_mode;
                    op_d       = sel_op;
                    dig_d      = sel_dig;
                end else begin
                    state_d    = S_IDLE;
                    hold_cnt_d = '0;
                    en_d       = 1'b0;
                    grant_d    = 3'b000;
                    mode_d     = 1'b0;
                    op_d       = 3'd0;
                    dig_d      = 4'd0;
                end
            end
            S_SHOW: begin
                hold_cnt_d = hold_cnt_inc;
                if (!own_req) begin
                    // Dropping the request before the hold time freezes the payload.
                    if (held) state_d = S_BLANK;
                    else      state_d = S_LINGER;
                end else if (higher_req && held) begin
                    state_d = S_BLANK;
                end else begin
                    mode_d = sel_mode;
                    op_d   = sel_op;
                    dig_d  = sel_dig;
                end
            end
            S_LINGER: begin
                hold_cnt_d = hold_cnt_inc;
                if (held) begin
                    state_d = S_BLANK;
                end else if (own_req) begin
                    // Owner came back: resume live updates, hold time keeps running.
                    state_d = S_SHOW;
                    mode_d  = sel_mode;
                    op_d    = sel_op;
                    dig_d   = sel_dig;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d == S_BLANK) begin
            hold_cnt_d = '0;
            en_d       = 1'b0;
            grant_d    = 3'b000;
            mode_d     = 1'b0;
            op_d       = 3'd0;
            dig_d      = 4'd0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State, hold counter and registered outputs; reset clears the display at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            owner_q    <= 2'd0;
            hold_cnt_q <= '0;
            en_q       <= 1'b0;
            mode_q     <= 1'b0;
            op_q       <= 3'd0;
            dig_q      <= 4'd0;
            grant_q    <= 3'b000;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            hold_cnt_q <= hold_cnt_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            op_q       <= op_d;
            dig_q      <= dig_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
        end
    end

    assign o_en        = en_q;
    assign o_disp_mode = mode_q;
    assign o_op_code   = op_q;
    assign o_digit_val = dig_q;
    assign o_grant     = grant_q;
    assign o_busy      = busy_q;

endmodule

// File: doc/seg7_disp_arbiter.md
# seg7_disp_arbiter

Shares the single 7-segment display driver between three independent requesters, such as error/status, operation menu and result readout. It selects one requester by fixed priority and enforces a minimum on-screen hold time so a message cannot flicker. It inserts one blank cycle on every owner change, which restarts the driver's scan sequence, and presents the winner's enable, mode, op code and digit value as registered outputs. It sits between the calculator control FSMs and the display driver's `i_en`, `i_disp_mode`, `i_op_code` and `i_digit_val` inputs.

## Interface
- `HOLD_CYC`, default 50_000_000: minimum cycles a grant stays on screen before it can be released or preempted; legal range is 1 or more.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: asynchronous, active-low reset. One clock domain only.
- `i_req` input, 3 bits: request per requester; bit 0 has the highest priority and bit 2 the lowest.
- `i_mode` input, 3 bits: per-requester display mode; 0 = op symbol, 1 = number.
- `i_op0`, `i_op1`, `i_op2` inputs, 3 bits each: per-requester op code.
- `i_dig0`, `i_dig1`, `i_dig2` inputs, 4 bits each: per-requester digit value, 0–15.
- `o_en` output, 1 bit: display enable to the driver.
- `o_disp_mode` output, 1 bit: display mode of the granted requester.
- `o_op_code` output, 3 bits: op code of the granted requester.
- `o_digit_val` output, 4 bits: digit value of the granted requester.
- `o_grant` output, 3 bits: one-hot current owner; all zeros when none.
- `o_busy` output, 1 bit: high in every state except IDLE.

## Operation
- FSM states are IDLE, SHOW, LINGER and BLANK.
- `hold_cnt` is `$clog2(HOLD_CYC+1)` bits wide. It is cleared on every new grant, increments once per cycle in SHOW and LINGER, and saturates at `HOLD_CYC`. `held` means `hold_cnt == HOLD_CYC`.
- `win` is the lowest-indexed set bit of `i_req`, evaluated combinationally.
- IDLE:
  - All outputs are 0.
  - If `i_req != 0`: grant `win`, load its payload, clear `hold_cnt`, go to SHOW.
- SHOW:
  - While the owner's request is high, the payload is re-registered every cycle from the owner's inputs (live update).
  - If the owner's request drops and `held` is false: go to LINGER and freeze the payload.
  - If the owner's request drops and `held` is true: go to BLANK.
  - If a higher-priority request is high and `held` is true: go to BLANK (preemption).
  - If a higher-priority request is high and `held` is false: stay in SHOW.
  - Lower-priority requests never preempt.
- LINGER:
  - The frozen payload is shown with `o_en = 1`; the owner's inputs are ignored.
  - When `held` becomes true: go to BLANK.
  - If the owner re-asserts its request in LINGER: return to SHOW without clearing `hold_cnt`.
- BLANK:
  - Lasts exactly one cycle.
  - `o_en = 0`, `o_grant = 0`, and the payload outputs are 0.
  - Next state: if `i_req != 0`, grant `win` (which may be the same requester), clear `hold_cnt`, go to SHOW; otherwise go to IDLE.
- `o_en = 1` in SHOW and LINGER only.
- `o_grant` is non-zero in exactly those states and is always one-hot.
- When the owner's request drops and a higher-priority request arrives in the same cycle with `held` false: LINGER takes precedence.

## Timing
- Reset values: all outputs 0, FSM in IDLE, `hold_cnt = 0`.
- Reset is asynchronous. Asserting it mid-grant forces `o_en` and `o_grant` to 0 immediately, without waiting for a clock edge.
- All outputs are registered and change only on a `clk` rising edge.
- Request to display, from IDLE: `i_req` is sampled high at edge t; `o_en`, `o_grant` and the payload are valid after edge t+1 (1-cycle latency).
- Owner change: the transition condition is true at edge t → BLANK after t+1 → new owner shown after t+2.
- The minimum visible time per grant is `HOLD_CYC` + 1 cycles of `o_en = 1`. A one-cycle request pulse is therefore still displayed for that long.
- Live payload changes by the owner in SHOW appear one cycle after they are sampled.

## Test plan
Benches use `HOLD_CYC = 4`.
- **Reset:** assert `rst_n = 0` mid-SHOW, between clock edges → outputs go to 0 immediately. Release reset with `i_req = 0` → IDLE, all outputs 0.
- **Single request:** `i_req = 3'b100`, `i_dig2 = 7`, `i_mode[2] = 1` → next cycle `o_grant = 3'b100`, `o_en = 1`, `o_digit_val = 7`, `o_disp_mode = 1`.
- **Pulse linger:** one-cycle pulse on `i_req[1]` with op 3 → `o_en = 1` and `o_op_code = 3` for exactly 5 cycles, then 1 BLANK cycle, then IDLE.
- **Preemption gating:** requester 2 is granted, and `i_req[0]` rises 1 cycle later → requester 2 stays owner until `hold_cnt = 4`, then 1 cycle of `o_en = 0`, then `o_grant = 3'b001`. Raising `i_req[2]` while requester 0 owns the display causes no change.
- **Simultaneous requests:** `i_req = 3'b111` in IDLE → `o_grant = 3'b001`. Requester 0 drops after 6 cycles → BLANK, then `o_grant = 3'b010`.
- **Live update:** while requester 1 is granted, change `i_dig1` from 3 to 12 → `o_digit_val = 12` one cycle later, `o_en` stays high and there is no BLANK cycle.
